// File: rtl/deser8_if.sv
// Serial-in / byte-out bus for deser8: bit stream in, assembled byte and
// status flags out. The producer/consumer side uses master, the block uses slave.
interface deser8_if;
   logic       din;
   logic       din_valid;
   logic       sof;
   logic       dout_ack;
   logic [0:7] dout;
   logic       dout_valid;
   logic [2:0] bit_cnt;
   logic       overrun;
   logic       frame_err;

   modport master (
      output din, din_valid, sof, dout_ack,
      input  dout, dout_valid, bit_cnt, overrun, frame_err
   );

   modport slave (
      input  din, din_valid, sof, dout_ack,
      output dout, dout_valid, bit_cnt, overrun, frame_err
   );
endinterface

// File: rtl/deser8.sv
// deser8: 1-bit serial to 8-bit parallel deserializer with sof framing,
// held-byte handshake, overrun and frame-error pulses.
module deser8 (
   input  logic     clk,
   input  logic     reset,
   deser8_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [0:7] acc_q, acc_d;
   logic [0:7] dout_q, dout_d;
   logic       dout_valid_q, dout_valid_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q, frame_err_d;
   logic       done;

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         acc_q        <= 8'b0;
         dout_q       <= 8'b0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Next state: bit accumulation, framing, and output byte handshake.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
      done         = 1'b0;

      if (bus.din_valid) begin
         case (state_q)
            IDLE: begin
               // Without a sof the stream is unframed; drop the bit.
               if (bus.sof) begin
                  acc_d[0] = bus.din;
                  cnt_d    = 3'd1;
                  state_d  = RECV;
               end
            end
            RECV: begin
               if (bus.sof && cnt_q != 3'd0) begin
                  // Resync: partial byte is abandoned, this bit is index 0.
                  acc_d[0]    = bus.din;
                  cnt_d       = 3'd1;
                  frame_err_d = 1'b1;
               end else begin
                  // sof at cnt=0 lands here too: it is just the next index-0 bit.
                  acc_d[cnt_q] = bus.din;
                  cnt_d        = cnt_q + 3'd1;
                  done         = (cnt_q == 3'd7);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (done) begin
         // New byte always wins; it is an overrun only if the old one was never taken.
         dout_d       = {acc_q[0:6], bus.din};
         dout_valid_d = 1'b1;
         overrun_d    = dout_valid_q && !bus.dout_ack;
      end else if (bus.dout_ack) begin
         dout_valid_d = 1'b0;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.bit_cnt    = cnt_q;
   assign bus.overrun    = overrun_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: directed scenarios plus random traffic, all outputs
// compared every cycle against a bit-list reference model.
module tb_deser8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   deser8_if bus ();

   deser8 dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: a frame flag and the list of bits gathered so far.
   bit         in_frame;
   bit         bits[$];
   logic [0:7] m_dout;
   bit         m_dv, m_ov, m_fe;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic v, d, s, a, r);
      bit done;
      done = 1'b0;
      if (r) begin
         in_frame = 1'b0;
         bits.delete();
         m_dout = 8'b0;
         m_dv = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
      end else begin
         m_ov = 1'b0;
         m_fe = 1'b0;
         if (v) begin
            if (s) begin
               if (in_frame && bits.size() != 0) m_fe = 1'b1;
               bits.delete();
               bits.push_back(d);
               in_frame = 1'b1;
            end else if (in_frame) begin
               bits.push_back(d);
            end
            if (bits.size() == 8) begin
               done = 1'b1;
               for (int k = 0; k < 8; k++) m_dout[k] = bits[k];
               bits.delete();
            end
         end
         if (done) begin
            m_ov = m_dv && !a;
            m_dv = 1'b1;
         end else if (a) begin
            m_dv = 1'b0;
         end
      end
   endtask

   // One clock: drive inputs, advance model, check every output after the edge.
   task automatic cyc(input logic v, d, s, a, r);
      bus.din_valid = v; bus.din = d; bus.sof = s; bus.dout_ack = a; rst = r;
      @(posedge clk);
      model(v, d, s, a, r);
      #1;
      chk("dout",       32'(bus.dout),       32'(m_dout));
      chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
      chk("bit_cnt",    32'(bus.bit_cnt),    32'(bits.size()));
      chk("overrun",    32'(bus.overrun),    32'(m_ov));
      chk("frame_err",  32'(bus.frame_err),  32'(m_fe));
   endtask

   // Eight valid bits of b, index 0 first; optional sof on bit 0 and ack on bit 7.
   task automatic send_byte(input logic [0:7] b, input bit first_sof, input bit ack_last, input bit gaps);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, b[k], (k == 0) && first_sof, (k == 7) && ack_last, 1'b0);
         if (gaps && k != 7) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      bus.din = 0; bus.din_valid = 0; bus.sof = 0; bus.dout_ack = 0; rst = 1;
      in_frame = 0; m_dout = 0; m_dv = 0; m_ov = 0; m_fe = 0;

      // Reset state
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, 1, 1, 1);
      chk("rst_dv",  32'(bus.dout_valid), 32'd0);
      chk("rst_cnt", 32'(bus.bit_cnt),    32'd0);

      // Unframed bits in IDLE are ignored
      send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
      chk("idle_ign_dv", 32'(bus.dout_valid), 32'd0);

      // Gapless byte with sof
      send_byte(8'b10110010, 1'b1, 1'b0, 1'b0);
      chk("b1_dout", 32'(bus.dout),       32'hB2);
      chk("b1_dv",   32'(bus.dout_valid), 32'd1);
      chk("b1_cnt",  32'(bus.bit_cnt),    32'd0);
      cyc(0, 0, 0, 1, 0);
      chk("ack_clr", 32'(bus.dout_valid), 32'd0);

      // Gappy byte, no sof needed (cnt already 0)
      send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
      chk("gap_dout", 32'(bus.dout),       32'hA5);
      chk("gap_dv",   32'(bus.dout_valid), 32'd1);
      cyc(0, 0, 0, 1, 0);

      // Back-to-back with no ack -> overrun on second
      send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
      chk("bb1_ov", 32'(bus.overrun), 32'd0);
      send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
      chk("bb2_ov",   32'(bus.overrun),    32'd1);
      chk("bb2_dout", 32'(bus.dout),       32'hC3);
      chk("bb2_dv",   32'(bus.dout_valid), 32'd1);
      cyc(0, 0, 0, 0, 0);
      chk("ov_pulse", 32'(bus.overrun), 32'd0);

      // Ack coinciding with completion
      send_byte(8'h5A, 1'b0, 1'b1, 1'b0);
      chk("ackc_dout", 32'(bus.dout),       32'h5A);
      chk("ackc_dv",   32'(bus.dout_valid), 32'd1);
      chk("ackc_ov",   32'(bus.overrun),    32'd0);
      cyc(0, 0, 0, 1, 0);
      chk("ackc_clr",  32'(bus.dout_valid), 32'd0);

      // sof mid-byte at bit_cnt=4
      for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
      chk("fe_pre_cnt", 32'(bus.bit_cnt), 32'd4);
      send_byte(8'h96, 1'b1, 1'b0, 1'b0);
      chk("fe_dout", 32'(bus.dout), 32'h96);
      cyc(0, 0, 0, 1, 0);

      // Reset mid-byte, then unframed bits are ignored
      send_byte(8'h00, 1'b0, 1'b0, 1'b0);
      cyc(0, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0);
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
      chk("pre_rst_cnt", 32'(bus.bit_cnt), 32'd5);
      cyc(1, 1, 0, 0, 1);
      send_byte(8'hE7, 1'b0, 1'b0, 1'b0);
      chk("post_rst_dv", 32'(bus.dout_valid), 32'd0);
      send_byte(8'h81, 1'b1, 1'b0, 1'b0);
      chk("post_rst_dout", 32'(bus.dout),       32'h81);
      chk("post_rst_dv2",  32'(bus.dout_valid), 32'd1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(99) < 70, 1'($urandom), $urandom_range(99) < 6,
             $urandom_range(99) < 30, $urandom_range(999) < 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Within the frame_err pulse of the mid-byte sof, bit_cnt must read 1.
   always @(posedge clk) begin
      #2;
      if (!rst && bus.frame_err === 1'b1) chk("fe_cnt", 32'(bus.bit_cnt), 32'd1);
   end

endmodule
